// File: rtl/sha256_arb_pkg.sv
// Shared types and constants for the SHA-256 core arbiter.
// The IV is not used by the arbiter itself; it is provided for core models in benches.
package sha256_arb_pkg;

    localparam int unsigned BlockW = 512;
    localparam int unsigned HashW  = 256;

    localparam logic [HashW-1:0] Sha256Iv =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    typedef enum logic [2:0] {
        StArb,
        StIssue,
        StGuard,
        StWait,
        StResp
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first eligible index
// at or above the pointer, wrapping around.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    elig_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    int pos;

    // Scan from the farthest offset down so the nearest eligible index wins.
    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        pos     = 0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            pos = (int'(ptr_i) + k) % int'(N);
            if (elig_i[IdxW'(pos)]) begin
                idx_o   = IdxW'(pos);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sha256_core_arbiter.sv
// Round-robin arbiter sharing one chained SHA-256 compression core among N_REQ
// requesters; the core stays locked to one requester for a whole message.
module sha256_core_arbiter
    import sha256_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned GUARD_CYC   = 2,
    parameter int unsigned TIMEOUT_CYC = 1023,
    localparam int unsigned IdW        = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*BlockW-1:0] req_block,
    input  logic [N_REQ-1:0]        req_first,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    rsp_valid,
    output logic [IdW-1:0]          rsp_id,
    output logic                    rsp_last,
    output logic                    rsp_err,
    output logic [HashW-1:0]        rsp_hash,
    output logic                    core_start,
    output logic [BlockW-1:0]       core_block,
    output logic                    core_init,
    input  logic                    core_ready,
    input  logic [HashW-1:0]        core_hash,
    output logic                    locked,
    output logic                    err_seq,
    output logic                    err_timeout
);

    localparam int unsigned CntMax = (TIMEOUT_CYC > GUARD_CYC) ? TIMEOUT_CYC : GUARD_CYC;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    arb_state_e        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [IdW-1:0]    owner_q, owner_d;
    logic [IdW-1:0]    rr_ptr_q, rr_ptr_d;
    logic              locked_q, locked_d;
    logic [BlockW-1:0] blk_q, blk_d;
    logic              first_q, first_d;
    logic              last_q, last_d;
    logic [HashW-1:0]  rsp_hash_q, rsp_hash_d;
    logic [IdW-1:0]    rsp_id_q, rsp_id_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;
    logic              err_seq_q, err_seq_d;
    logic              err_timeout_q, err_timeout_d;

    logic [N_REQ-1:0]  elig;
    logic [IdW-1:0]    pick_idx;
    logic              pick_found;
    logic              grant;

    // While locked only the owner may proceed, whatever its first flag.
    always_comb begin
        elig = '0;
        if (locked_q) begin
            elig = req_valid & (N_REQ'(1) << owner_q);
        end else begin
            elig = req_valid & req_first;
        end
    end

    rr_pick #(
        .N    (N_REQ),
        .IdxW (IdW)
    ) u_rr_pick (
        .elig_i  (elig),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Gated by rst_n so no accept pulse is shown for a grant that reset discards.
    assign grant     = (state_q == StArb) && pick_found && rst_n;
    assign req_ready = grant ? (N_REQ'(1) << pick_idx) : '0;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        locked_d      = locked_q;
        blk_d         = blk_q;
        first_d       = first_q;
        last_d        = last_q;
        rsp_hash_d    = rsp_hash_q;
        rsp_id_d      = rsp_id_q;
        rsp_last_d    = rsp_last_q;
        rsp_err_d     = rsp_err_q;
        err_seq_d     = err_seq_q;
        err_timeout_d = err_timeout_q;

        unique case (state_q)
            StArb: begin
                if (!locked_q && |(req_valid & ~req_first)) begin
                    err_seq_d = 1'b1;
                end
                if (grant) begin
                    owner_d  = pick_idx;
                    locked_d = 1'b1;
                    blk_d    = req_block[int'(pick_idx) * int'(BlockW) +: BlockW];
                    first_d  = req_first[pick_idx];
                    last_d   = req_last[pick_idx];
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = (GUARD_CYC == 0) ? StWait : StGuard;
            end
            StGuard: begin
                if (cnt_q == CntW'(GUARD_CYC - 1)) begin
                    cnt_d   = '0;
                    state_d = StWait;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWait: begin
                if (core_ready) begin
                    rsp_hash_d = core_hash;
                    rsp_err_d  = 1'b0;
                    rsp_id_d   = owner_q;
                    rsp_last_d = last_q;
                    state_d    = StResp;
                end else if (cnt_q == CntW'(TIMEOUT_CYC - 1)) begin
                    rsp_err_d     = 1'b1;
                    err_timeout_d = 1'b1;
                    rsp_id_d      = owner_q;
                    rsp_last_d    = last_q;
                    state_d       = StResp;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StResp: begin
                // A timeout leaves the core chaining state unusable, so unlock too.
                if (last_q || rsp_err_q) begin
                    locked_d = 1'b0;
                    rr_ptr_d = (owner_q == IdW'(N_REQ - 1)) ? '0 : owner_q + IdW'(1);
                end
                state_d = StArb;
            end
            default: state_d = StArb;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StArb;
            cnt_q         <= '0;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            locked_q      <= 1'b0;
            blk_q         <= '0;
            first_q       <= 1'b0;
            last_q        <= 1'b0;
            rsp_hash_q    <= '0;
            rsp_id_q      <= '0;
            rsp_last_q    <= 1'b0;
            rsp_err_q     <= 1'b0;
            err_seq_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            locked_q      <= locked_d;
            blk_q         <= blk_d;
            first_q       <= first_d;
            last_q        <= last_d;
            rsp_hash_q    <= rsp_hash_d;
            rsp_id_q      <= rsp_id_d;
            rsp_last_q    <= rsp_last_d;
            rsp_err_q     <= rsp_err_d;
            err_seq_q     <= err_seq_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign rsp_valid   = (state_q == StResp);
    assign rsp_id      = rsp_id_q;
    assign rsp_last    = rsp_last_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_hash    = rsp_hash_q;
    assign core_start  = (state_q == StIssue);
    assign core_block  = blk_q;
    assign core_init   = first_q;
    assign locked      = locked_q;
    assign err_seq     = err_seq_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sha256_core_arbiter.sv
// Directed bench for sha256_core_arbiter with a behavioural chained SHA-256 core;
// expected digests are the published SHA-256 test vectors.
module tb_sha256_core_arbiter;
    import sha256_arb_pkg::*;

    localparam int unsigned NR  = 4;
    localparam int unsigned LAT = 4;

    localparam logic [511:0] AbcBlk = {32'h61626380, 416'h0, 64'h18};
    localparam logic [511:0] Lng0 = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071,
                                     32'h80000000, 32'h0};
    localparam logic [511:0] Lng1 = {448'h0, 64'h1c0};
    localparam logic [255:0] AbcDig =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] LngDig =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
        32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
        32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
        32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
        32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
        32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct packed {
        logic [31:0]  cyc;
        logic [1:0]   id;
        logic         last;
        logic         err;
        logic [255:0] hash;
    } rsp_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [NR-1:0]       req_valid, req_first, req_last, req_ready;
    logic [NR*512-1:0]   req_block;
    logic                rsp_valid, rsp_last, rsp_err, core_start, core_init, core_ready;
    logic [1:0]          rsp_id;
    logic [255:0]        rsp_hash, core_hash;
    logic [511:0]        core_block;
    logic                locked, err_seq, err_timeout;

    always #5 clk = ~clk;

    sha256_core_arbiter #(
        .N_REQ       (NR),
        .GUARD_CYC   (2),
        .TIMEOUT_CYC (15)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_block   (req_block),
        .req_first   (req_first),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_last    (rsp_last),
        .rsp_err     (rsp_err),
        .rsp_hash    (rsp_hash),
        .core_start  (core_start),
        .core_block  (core_block),
        .core_init   (core_init),
        .core_ready  (core_ready),
        .core_hash   (core_hash),
        .locked      (locked),
        .err_seq     (err_seq),
        .err_timeout (err_timeout)
    );

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Chained core model: ready drops for LAT cycles after each start.
    logic [255:0] h_q, nxt_q;
    logic         busy_q;
    int unsigned  lat_q;
    logic         hang = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            h_q    <= Sha256Iv;
            nxt_q  <= '0;
            busy_q <= 1'b0;
            lat_q  <= 0;
        end else if (core_start) begin
            nxt_q  <= compress(core_init ? Sha256Iv : h_q, core_block);
            busy_q <= 1'b1;
            lat_q  <= LAT;
        end else if (busy_q) begin
            if (lat_q == 1) begin
                busy_q <= 1'b0;
                h_q    <= nxt_q;
            end else begin
                lat_q <= lat_q - 1;
            end
        end
    end

    assign core_ready = !busy_q && !hang;
    assign core_hash  = h_q;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [513:0] sq [NR][$];
    int           grant_log[$], grant_cyc[$], start_cyc[$], start_init[$];
    rsp_t         rsp_log[$];
    int           checks = 0;
    int           errors = 0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [513:0] ent(input logic f, input logic l, input logic [511:0] b);
        return {f, l, b};
    endfunction

    function automatic int qat(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    function automatic rsp_t rl(input int i);
        rsp_t r;
        r = '0;
        if (i < rsp_log.size()) r = rsp_log[i];
        return r;
    endfunction

    function automatic int gseq(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s = s * 16 + (qat(grant_log, i) & 15);
        return s;
    endfunction

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            if (sq[i].size() > 0) begin
                req_valid[i]             = 1'b1;
                req_first[i]             = sq[i][0][513];
                req_last[i]              = sq[i][0][512];
                req_block[i*512 +: 512]  = sq[i][0][511:0];
            end else begin
                req_valid[i]             = 1'b0;
                req_first[i]             = 1'b0;
                req_last[i]              = 1'b0;
                req_block[i*512 +: 512]  = '0;
            end
        end
    endtask

    task automatic clear_logs();
        grant_log.delete(); grant_cyc.delete(); start_cyc.delete(); start_init.delete();
        rsp_log.delete();
    endtask

    task automatic step();
        logic [NR-1:0] gr;
        rsp_t          r;
        @(negedge clk);
        gr = req_ready;
        for (int i = 0; i < NR; i++) begin
            if (gr[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end
        if (core_start) begin
            start_cyc.push_back(cyc);
            start_init.push_back(int'(core_init));
        end
        if (rsp_valid) begin
            r.cyc = cyc; r.id = rsp_id; r.last = rsp_last; r.err = rsp_err; r.hash = rsp_hash;
            rsp_log.push_back(r);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (gr[i] && sq[i].size() > 0) void'(sq[i].pop_front());
        end
        drive();
    endtask

    task automatic run_rsp(input int n, input int budget);
        int k = 0;
        while (rsp_log.size() < n && k < budget) begin
            step();
            k++;
        end
        check("rsp_count", rsp_log.size(), n);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) sq[i].delete();
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_req_ready"}, req_ready, '0);
        check({tag, "_flags"}, {rsp_valid, rsp_last, rsp_err, core_start, core_init, locked,
                                err_seq, err_timeout}, 8'h00);
        check({tag, "_rsp_hash"}, rsp_hash, '0);
        check({tag, "_core_block"}, core_block, '0);
        check({tag, "_rsp_id"}, rsp_id, 2'd0);
    endtask

    initial begin
        drive();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;

        // Single "abc" block from requester 0.
        clear_logs();
        sq[0].push_back(ent(1'b1, 1'b1, AbcBlk));
        drive();
        run_rsp(1, 50);
        check("abc_id", rl(0).id, 2'd0);
        check("abc_last_err", {rl(0).last, rl(0).err}, 2'b10);
        check("abc_hash", rl(0).hash, AbcDig);
        check("abc_accept_to_start", qat(start_cyc, 0) - qat(grant_cyc, 0), 1);
        check("abc_accept_to_rsp", int'(rl(0).cyc) - qat(grant_cyc, 0), 7);
        check("abc_unlocked", locked, 1'b0);
        repeat (3) step();
        check("abc_hash_hold", {rsp_valid, rsp_hash}, {1'b0, AbcDig});

        // Requester 1 "abc" competes with requester 2's two-block message.
        do_reset();
        sq[1].push_back(ent(1'b1, 1'b1, AbcBlk));
        sq[2].push_back(ent(1'b1, 1'b0, Lng0));
        sq[2].push_back(ent(1'b0, 1'b1, Lng1));
        drive();
        run_rsp(3, 100);
        check("two_grant_order", gseq(3), 32'h122);
        check("two_init_seq", {qat(start_init, 0) == 1, qat(start_init, 1) == 1,
                               qat(start_init, 2) == 1}, 3'b110);
        check("two_r0", {rl(0).id, rl(0).last, rl(0).hash}, {2'd1, 1'b1, AbcDig});
        check("two_r1_id_last", {rl(1).id, rl(1).last}, {2'd2, 1'b0});
        check("two_r2", {rl(2).id, rl(2).last, rl(2).err, rl(2).hash}, {2'd2, 2'b10, LngDig});

        // All four requesters hold "abc" continuously.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            sq[i].push_back(ent(1'b1, 1'b1, AbcBlk));
            sq[i].push_back(ent(1'b1, 1'b1, AbcBlk));
        end
        drive();
        run_rsp(8, 200);
        check("rr_grant_order", gseq(8), 32'h01230123);
        begin
            int good = 0;
            for (int i = 0; i < 8; i++) if (rl(i).hash === AbcDig && rl(i).last) good++;
            check("rr_good_hashes", good, 8);
        end

        // Non-first block from unlocked requester 3.
        do_reset();
        sq[3].push_back(ent(1'b0, 1'b1, AbcBlk));
        sq[0].push_back(ent(1'b1, 1'b1, AbcBlk));
        drive();
        run_rsp(1, 50);
        check("seq_grants", {grant_log.size() == 1, qat(grant_log, 0) == 0}, 2'b11);
        check("seq_hash", {rl(0).id, rl(0).hash}, {2'd0, AbcDig});
        sq[3].delete();
        drive();
        repeat (5) step();
        check("seq_err_sticky", {err_seq, grant_log.size() == 1}, 2'b11);

        // Core never ready: WAIT timeout on the first block of a two-block message.
        do_reset();
        hang = 1'b1;
        sq[0].push_back(ent(1'b1, 1'b0, Lng0));
        drive();
        run_rsp(1, 100);
        check("to_rsp", {rl(0).id, rl(0).last, rl(0).err}, {2'd0, 1'b0, 1'b1});
        check("to_start_to_rsp", int'(rl(0).cyc) - qat(start_cyc, 0), 18);
        check("to_after", {locked, err_timeout, rsp_err}, 3'b011);

        // Reset in WAIT of block 1 of 2, then a fresh "abc".
        clear_logs();
        sq[2].push_back(ent(1'b1, 1'b0, Lng0));
        sq[2].push_back(ent(1'b0, 1'b1, Lng1));
        drive();
        begin
            int k = 0;
            while (start_cyc.size() == 0 && k < 20) begin
                step();
                k++;
            end
        end
        repeat (4) step();
        check("mid_locked_before", {locked, core_block}, {1'b1, Lng0});
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) sq[i].delete();
        drive();
        @(posedge clk);
        #1;
        check_reset_vals("mid_reset");
        rst_n = 1'b1;
        hang = 1'b0;
        clear_logs();
        sq[1].push_back(ent(1'b1, 1'b1, AbcBlk));
        drive();
        run_rsp(1, 50);
        check("mid_fresh", {rl(0).id, rl(0).last, rl(0).err, rl(0).hash},
              {2'd1, 2'b10, AbcDig});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
